// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard/forwarding controller.
//   fwd_sel_e  - operand source select for the instruction in EXE.
//   sb_entry_t - one shadow-scoreboard entry (EXE, MEM or WB stage).
// SB_REG_BITS sizes the stored destination; raise it for register files
// wider than 16 entries.
package hazard_pkg;

  localparam int SB_REG_BITS = 4;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,  // operand from the ID/EXE register
    FWD_EXEMEM = 2'b01,  // ALU result sitting in EXE/MEM
    FWD_MEMWB  = 2'b10   // result sitting in MEM/WB
  } fwd_sel_e;

  typedef struct packed {
    logic                   valid;
    logic                   wb_en;
    logic [SB_REG_BITS-1:0] dst;
    logic                   is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational comparator of one ID source operand against
// one scoreboard entry.
//   id_valid_i   - instruction in ID is real
//   src_used_i   - this source is actually read
//   src_i        - source register address
//   ent_valid_i  - scoreboard entry holds a real instruction
//   ent_wb_en_i  - that instruction writes a register
//   ent_dst_i    - its destination
//   match_o      - the source depends on the entry
module hazard_match #(
  parameter int REG_BITS = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                id_valid_i,
  input  logic                src_used_i,
  input  logic [REG_BITS-1:0] src_i,
  input  logic                ent_valid_i,
  input  logic                ent_wb_en_i,
  input  logic [REG_BITS-1:0] ent_dst_i,
  output logic                match_o
);

  logic zero_src;

  // A hardwired-zero register never carries a dependency.
  assign zero_src = (ZERO_REG != 0) && (src_i == '0);

  assign match_o = id_valid_i && src_used_i && ent_valid_i && ent_wb_en_i &&
                   (src_i == ent_dst_i) && !zero_src;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard, forwarding and flush controller for the five-stage
// IF/ID/EXE/MEM/WB pipeline. Tracks EXE/MEM/WB in a shadow scoreboard.
//   clk, rst          - clock, synchronous active-high reset
//   id_*              - description of the instruction currently in ID
//   branch_taken      - branch resolved taken in EXE this cycle
//   mem_busy          - memory stage not ready; whole pipe freezes
//   pc_en, ifid_stop, ifid_flush, idexe_bubble, freeze - pipeline controls
//   id_bypass         - per source: take wb_result in ID (combinational)
//   fwd_sel           - per source: registered EXE operand select
//   stall_count, flush_count - saturating performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ARQ      = 16,
  parameter int REG_BITS = 4,
  parameter int NSRC     = 3,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NSRC*REG_BITS-1:0] id_src,
  input  logic [NSRC-1:0]          id_src_used,
  input  logic                     id_wb_en,
  input  logic [REG_BITS-1:0]      id_dst,
  input  logic                     id_is_load,
  input  logic                     branch_taken,
  input  logic                     mem_busy,
  output logic                     pc_en,
  output logic                     ifid_stop,
  output logic                     ifid_flush,
  output logic                     idexe_bubble,
  output logic                     freeze,
  output logic [NSRC-1:0]          id_bypass,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         flush_count
);

  // ARQ only documents the datapath width; the stored destination must fit.
  if (ARQ < 1 || REG_BITS > SB_REG_BITS) begin : g_param_range
  end

  sb_entry_t             e_q, e_d, m_q, m_d, w_q, w_d;
  logic [NSRC*2-1:0]     fwd_q, fwd_d, fwd_new;
  logic [CNT_W-1:0]      stall_q, stall_d, flush_q, flush_d;
  logic [NSRC-1:0]       hit_e, hit_m, hit_w;
  logic                  load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    hazard_match #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_match_e (
      .id_valid_i (id_valid),
      .src_used_i (id_src_used[k]),
      .src_i      (id_src[k*REG_BITS +: REG_BITS]),
      .ent_valid_i(e_q.valid),
      .ent_wb_en_i(e_q.wb_en),
      .ent_dst_i  (e_q.dst[REG_BITS-1:0]),
      .match_o    (hit_e[k])
    );
    hazard_match #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_match_m (
      .id_valid_i (id_valid),
      .src_used_i (id_src_used[k]),
      .src_i      (id_src[k*REG_BITS +: REG_BITS]),
      .ent_valid_i(m_q.valid),
      .ent_wb_en_i(m_q.wb_en),
      .ent_dst_i  (m_q.dst[REG_BITS-1:0]),
      .match_o    (hit_m[k])
    );
    hazard_match #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_match_w (
      .id_valid_i (id_valid),
      .src_used_i (id_src_used[k]),
      .src_i      (id_src[k*REG_BITS +: REG_BITS]),
      .ent_valid_i(w_q.valid),
      .ent_wb_en_i(w_q.wb_en),
      .ent_dst_i  (w_q.dst[REG_BITS-1:0]),
      .match_o    (hit_w[k])
    );
  end

  // The register file writes on the same edge ID/EXE captures, so a WB
  // producer is bypassed straight into the ID operand mux.
  assign id_bypass = hit_w;

  assign load_use = (|hit_e) && e_q.is_load;

  // Forward select for the instruction about to enter EXE; E is the newest
  // producer and wins over M. A load in E never reaches here (it stalls).
  always_comb begin
    fwd_new = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (hit_e[k] && !e_q.is_load) begin
        fwd_new[k*2 +: 2] = FWD_EXEMEM;
      end else if (hit_m[k]) begin
        fwd_new[k*2 +: 2] = FWD_MEMWB;
      end else begin
        fwd_new[k*2 +: 2] = FWD_NONE;
      end
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_stop    = 1'b0;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    freeze       = 1'b0;
    e_d          = e_q;
    m_d          = m_q;
    w_d          = w_q;
    fwd_d        = fwd_q;
    stall_d      = stall_q;
    flush_d      = flush_q;

    if (mem_busy) begin
      // Everything holds; a pending branch re-asserts once memory is ready.
      freeze    = 1'b1;
      pc_en     = 1'b0;
      ifid_stop = 1'b1;
    end else if (branch_taken) begin
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
      e_d          = '0;
      m_d          = e_q;
      w_d          = m_q;
      fwd_d        = '0;
      flush_d      = sat_inc(flush_q);
    end else if (load_use) begin
      pc_en        = 1'b0;
      ifid_stop    = 1'b1;
      idexe_bubble = 1'b1;
      e_d          = '0;
      m_d          = e_q;
      w_d          = m_q;
      fwd_d        = '0;
      stall_d      = sat_inc(stall_q);
    end else begin
      e_d.valid    = id_valid;
      e_d.wb_en    = id_wb_en;
      e_d.dst      = SB_REG_BITS'(id_dst);
      e_d.is_load  = id_is_load;
      m_d          = e_q;
      w_d          = m_q;
      fwd_d        = fwd_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      fwd_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      fwd_q   <= fwd_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign fwd_sel     = fwd_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RB = 4;
  localparam int NS = 3;
  localparam int CW = 4;

  // Control vector order: {pc_en, ifid_stop, ifid_flush, idexe_bubble, freeze}
  localparam logic [4:0] CTL_RUN    = 5'b10000;
  localparam logic [4:0] CTL_STALL  = 5'b01010;
  localparam logic [4:0] CTL_FLUSH  = 5'b10110;
  localparam logic [4:0] CTL_FREEZE = 5'b01001;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [NS*RB-1:0]  id_src;
  logic [NS-1:0]     id_src_used;
  logic              id_wb_en;
  logic [RB-1:0]     id_dst;
  logic              id_is_load;
  logic              branch_taken;
  logic              mem_busy;
  logic              pc_en, ifid_stop, ifid_flush, idexe_bubble, freeze;
  logic [NS-1:0]     id_bypass;
  logic [NS*2-1:0]   fwd_sel;
  logic [CW-1:0]     stall_count, flush_count;
  logic [4:0]        ctl;

  int checks   = 0;
  int failures = 0;

  assign ctl = {pc_en, ifid_stop, ifid_flush, idexe_bubble, freeze};

  hazard_ctrl #(.ARQ(16), .REG_BITS(RB), .NSRC(NS), .ZERO_REG(1), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_wb_en    (id_wb_en),
    .id_dst      (id_dst),
    .id_is_load  (id_is_load),
    .branch_taken(branch_taken),
    .mem_busy    (mem_busy),
    .pc_en       (pc_en),
    .ifid_stop   (ifid_stop),
    .ifid_flush  (ifid_flush),
    .idexe_bubble(idexe_bubble),
    .freeze      (freeze),
    .id_bypass   (id_bypass),
    .fwd_sel     (fwd_sel),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // a further unit later, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // src packs {src3, src2, src1}
  task automatic set_id(input logic v, input logic [11:0] src, input logic [2:0] used,
                        input logic wb, input logic [3:0] dst, input logic ld);
    id_valid    = v;
    id_src      = src;
    id_src_used = used;
    id_wb_en    = wb;
    id_dst      = dst;
    id_is_load  = ld;
  endtask

  task automatic drain();
    set_id(1'b0, 12'h000, 3'b000, 1'b0, 4'h0, 1'b0);
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1'b0, 12'h000, 3'b000, 1'b0, 4'h0, 1'b0);
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RUN);
    end
    checks++;
    if ({fwd_sel, id_bypass} !== 9'd0) begin
      failures++; $display("FAIL reset_fwd_byp got=%b exp=0", {fwd_sel, id_bypass});
    end
    checks++;
    if ({stall_count, flush_count} !== 8'd0) begin
      failures++; $display("FAIL reset_counters got=%h exp=00", {stall_count, flush_count});
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      checks++;
      if ({ctl, id_bypass, fwd_sel, stall_count, flush_count} !== {CTL_RUN, 17'd0}) begin
        failures++;
        $display("FAIL idle_cycle%0d ctl=%b byp=%b fwd=%b sc=%0d fc=%0d exp ctl=%b rest 0",
                 i, ctl, id_bypass, fwd_sel, stall_count, flush_count, CTL_RUN);
      end
    end
  endtask

  task automatic test_alu_fwd();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd3, 1'b0);  // ALU r3
    tick();
    set_id(1'b1, 12'h003, 3'b001, 1'b0, 4'd0, 1'b0);  // reads r3 as src1
    #1;
    checks++;
    if (ctl !== CTL_RUN || id_bypass !== 3'b000) begin
      failures++; $display("FAIL alu_consumer_id ctl=%b byp=%b exp ctl=%b byp=000", ctl, id_bypass, CTL_RUN);
    end
    tick();
    set_id(1'b0, 12'h000, 3'b000, 1'b0, 4'h0, 1'b0);
    #1;
    checks++;
    if (fwd_sel !== 6'b000001) begin
      failures++; $display("FAIL alu_fwd_sel got=%b exp=000001", fwd_sel);
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd5, 1'b1);  // LOAD r5
    tick();
    set_id(1'b1, 12'h050, 3'b010, 1'b0, 4'd0, 1'b0);  // reads r5 as src2
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      failures++; $display("FAIL loaduse_stall_ctl got=%b exp=%b", ctl, CTL_STALL);
    end
    tick();
    #1;
    checks++;
    if (ctl !== CTL_RUN || stall_count !== 4'd1) begin
      failures++; $display("FAIL loaduse_after ctl=%b sc=%0d exp ctl=%b sc=1", ctl, stall_count, CTL_RUN);
    end
    tick();
    set_id(1'b0, 12'h000, 3'b000, 1'b0, 4'h0, 1'b0);
    #1;
    checks++;
    if (fwd_sel !== 6'b001000 || stall_count !== 4'd1) begin
      failures++; $display("FAIL loaduse_fwd fwd=%b sc=%0d exp fwd=001000 sc=1", fwd_sel, stall_count);
    end
  endtask

  task automatic test_branch();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd7, 1'b0);  // wrong-path ALU r7
    branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_FLUSH) begin
      failures++; $display("FAIL branch_ctl got=%b exp=%b", ctl, CTL_FLUSH);
    end
    tick();
    branch_taken = 1'b0;
    set_id(1'b1, 12'h007, 3'b001, 1'b0, 4'd0, 1'b0);  // reads r7
    #1;
    checks++;
    if (flush_count !== 4'd1 || ctl !== CTL_RUN) begin
      failures++; $display("FAIL branch_after fc=%0d ctl=%b exp fc=1 ctl=%b", flush_count, ctl, CTL_RUN);
    end
    tick();
    #1;
    checks++;
    if (fwd_sel !== 6'b000000) begin
      failures++; $display("FAIL branch_squashed_fwd got=%b exp=000000", fwd_sel);
    end
  endtask

  task automatic test_branch_vs_loaduse();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd5, 1'b1);  // LOAD r5
    tick();
    set_id(1'b1, 12'h050, 3'b010, 1'b0, 4'd0, 1'b0);
    branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_FLUSH) begin
      failures++; $display("FAIL brlu_ctl got=%b exp=%b", ctl, CTL_FLUSH);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (stall_count !== 4'd1 || flush_count !== 4'd2) begin
      failures++; $display("FAIL brlu_counters sc=%0d fc=%0d exp sc=1 fc=2", stall_count, flush_count);
    end
  endtask

  task automatic test_mem_busy();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd9, 1'b0);  // ALU r9
    tick();
    set_id(1'b1, 12'h009, 3'b001, 1'b0, 4'd0, 1'b0);  // reads r9
    mem_busy     = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_FREEZE || flush_count !== 4'd2) begin
        failures++; $display("FAIL busy_cycle%0d ctl=%b fc=%0d exp ctl=%b fc=2", i, ctl, flush_count, CTL_FREEZE);
      end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_FLUSH) begin
      failures++; $display("FAIL busy_release_ctl got=%b exp=%b", ctl, CTL_FLUSH);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (flush_count !== 4'd3 || ctl !== CTL_RUN) begin
      failures++; $display("FAIL busy_flush_once fc=%0d ctl=%b exp fc=3 ctl=%b", flush_count, ctl, CTL_RUN);
    end
    tick();
    #1;
    // r9 was held in E through the freeze, so it is now in M.
    checks++;
    if (fwd_sel !== 6'b000010) begin
      failures++; $display("FAIL busy_held_sb_fwd got=%b exp=000010", fwd_sel);
    end
  endtask

  task automatic test_zero_reg();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd0, 1'b1);  // LOAD r0
    tick();
    set_id(1'b1, 12'h000, 3'b001, 1'b0, 4'd0, 1'b0);  // reads r0
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_RUN || id_bypass !== 3'b000) begin
        failures++; $display("FAIL zero_cycle%0d ctl=%b byp=%b exp ctl=%b byp=000", i, ctl, id_bypass, CTL_RUN);
      end
      tick();
      #1;
      checks++;
      if (fwd_sel !== 6'b000000) begin
        failures++; $display("FAIL zero_fwd%0d got=%b exp=000000", i, fwd_sel);
      end
    end
  endtask

  task automatic test_bypass();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd4, 1'b0);  // ALU r4
    tick();
    set_id(1'b0, 12'h000, 3'b000, 1'b0, 4'h0, 1'b0);
    tick();
    tick();
    set_id(1'b1, 12'h400, 3'b100, 1'b0, 4'd0, 1'b0);  // reads r4 as src3
    #1;
    checks++;
    if (id_bypass !== 3'b100 || ctl !== CTL_RUN) begin
      failures++; $display("FAIL bypass_w byp=%b ctl=%b exp byp=100 ctl=%b", id_bypass, ctl, CTL_RUN);
    end
    tick();
    #1;
    checks++;
    if (fwd_sel !== 6'b000000) begin
      failures++; $display("FAIL bypass_fwd got=%b exp=000000", fwd_sel);
    end
  endtask

  task automatic test_rst_during_stall();
    drain();
    set_id(1'b1, 12'h000, 3'b000, 1'b1, 4'd5, 1'b1);  // LOAD r5
    tick();
    set_id(1'b1, 12'h005, 3'b001, 1'b0, 4'd0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      failures++; $display("FAIL rst_pre_stall got=%b exp=%b", ctl, CTL_STALL);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RUN || stall_count !== 4'd0 || flush_count !== 4'd0 || fwd_sel !== 6'd0) begin
      failures++;
      $display("FAIL rst_clears ctl=%b sc=%0d fc=%0d fwd=%b exp ctl=%b sc=0 fc=0 fwd=0",
               ctl, stall_count, flush_count, fwd_sel, CTL_RUN);
    end
  endtask

  task automatic test_saturation();
    drain();
    // LOAD r1 reading r1, held in ID: stalls every other cycle.
    set_id(1'b1, 12'h001, 3'b001, 1'b1, 4'd1, 1'b1);
    repeat (4) tick();
    #1;
    checks++;
    if (stall_count !== 4'd2) begin
      failures++; $display("FAIL sat_partial got=%0d exp=2", stall_count);
    end
    repeat (36) tick();
    #1;
    checks++;
    if (stall_count !== 4'hF) begin
      failures++; $display("FAIL sat_hold got=%0d exp=15", stall_count);
    end
    set_id(1'b0, 12'h000, 3'b000, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_alu_fwd();
    test_load_use();
    test_branch();
    test_branch_vs_loaduse();
    test_mem_busy();
    test_zero_reg();
    test_bypass();
    test_rst_during_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
